// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory address/data, redirect and decode handshake of the fetch stage.
interface instr_fetch_unit_if #(
    parameter int DEPTH = 4
) ();
    logic [31:0]            pc_addr_o;
    logic [31:0]            instr_i;
    logic                   redirect_i;
    logic [31:0]            redirect_pc_i;
    logic [31:0]            instr_o;
    logic [31:0]            instr_pc_o;
    logic                   valid_o;
    logic                   ready_i;
    logic [$clog2(DEPTH):0] count_o;
    logic                   end_o;

    modport master (
        output pc_addr_o, instr_o, instr_pc_o, valid_o, count_o, end_o,
        input  instr_i, redirect_i, redirect_pc_i, ready_i
    );

    modport slave (
        input  pc_addr_o, instr_o, instr_pc_o, valid_o, count_o, end_o,
        output instr_i, redirect_i, redirect_pc_i, ready_i
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner feeding a first-word-fall-through fetch queue drained by decode; redirects flush and reload the PC.
module instr_fetch_unit #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input logic                clk_i,
    input logic                rst_i,
    instr_fetch_unit_if.master bus
);
    localparam int          AW    = $clog2(DEPTH);
    localparam int          CW    = AW + 1;
    localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'd4;

    logic [63:0]   mem_q [DEPTH];
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid, pop, push, in_range;
    logic          unused_lsbs;

    always_comb begin
        valid      = count_q != '0;
        pop        = valid & bus.ready_i;
        in_range   = {1'b0, fetch_pc_q} < LIMIT;
        // a full queue can still accept the fetch when the head leaves in the same cycle
        push       = ~bus.redirect_i & in_range & ((count_q < CW'(DEPTH)) | pop);
        fetch_pc_d = bus.redirect_i ? {bus.redirect_pc_i[31:2], 2'b00} :
                     push ? fetch_pc_q + 32'd4 : fetch_pc_q;
        wr_d       = bus.redirect_i ? '0 : wr_q + AW'(push);
        rd_d       = bus.redirect_i ? '0 : rd_q + AW'(pop);
        count_d    = bus.redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) mem_q[wr_q] <= {bus.instr_i, fetch_pc_q};
    end

    assign unused_lsbs    = ^bus.redirect_pc_i[1:0];
    assign bus.pc_addr_o  = fetch_pc_q;
    assign bus.valid_o    = valid;
    assign bus.instr_o    = valid ? mem_q[rd_q][63:32] : '0;
    assign bus.instr_pc_o = valid ? mem_q[rd_q][31:0] : '0;
    assign bus.count_o    = count_q;
    assign bus.end_o      = ~in_range;
endmodule
